// File: rtl/hazard_scoreboard_pkg.sv
// Shared types and constants for the ID-stage hazard scoreboard: register
// address encoding and the classification of an accepted destination write.
package hazard_scoreboard_pkg;

   localparam int REG_ADDR_W   = 5;
   localparam int NREG_DEFAULT = 1 << REG_ADDR_W;
   localparam int PCNT_W       = 2;

   typedef logic [REG_ADDR_W-1:0] reg_addr_t;

   localparam reg_addr_t REG_ZERO = 5'd0;

   typedef enum logic [1:0] {
      WR_NONE = 2'd0,
      WR_ALU  = 2'd1,
      WR_LOAD = 2'd2,
      WR_MC   = 2'd3
   } wr_kind_t;

   // Writes to x0 or non-writing instructions leave the tracking untouched.
   function automatic wr_kind_t classify_write(
      input logic      regwrite,
      input reg_addr_t rd,
      input logic      is_load,
      input logic      is_mc
   );
      wr_kind_t kind;
      if (!regwrite || (rd == REG_ZERO)) begin
         kind = WR_NONE;
      end else if (is_load) begin
         kind = WR_LOAD;
      end else if (is_mc) begin
         kind = WR_MC;
      end else begin
         kind = WR_ALU;
      end
      return kind;
   endfunction

endpackage

// File: rtl/hazard_scoreboard_checker.sv
// Protocol checks for the scoreboard: a same-cycle multicycle issue must win
// over mc_done, and a stalled instruction is never accepted.
module hazard_scoreboard_checker (
   input logic clk,
   input logic rst,
   input logic mc_done,
   input logic mc_issue,
   input logic mc_busy,
   input logic stall,
   input logic accept
);

   a_issue_beats_done: assert property (
      @(posedge clk) disable iff (rst) (mc_done && mc_issue) |=> mc_busy
   );

   a_no_accept_when_stalled: assert property (
      @(posedge clk) disable iff (rst) !(stall && accept)
   );

endmodule

// File: rtl/hazard_scoreboard.sv
// ID-stage scoreboard: tracks load and multicycle destinations that forwarding
// cannot yet serve, and stalls the ID instruction until its operands are ready.
module hazard_scoreboard
   import hazard_scoreboard_pkg::*;
#(
   parameter int NREG         = NREG_DEFAULT,
   parameter int LOAD_BUBBLES = 1,
   parameter int STALL_CNT_W  = 32
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   issue_valid,
   input  logic                   issue_regwrite,
   input  logic [REG_ADDR_W-1:0]  issue_rd,
   input  logic                   issue_is_load,
   input  logic                   issue_is_mc,
   input  logic                   use_rs1,
   input  logic                   use_rs2,
   input  logic [REG_ADDR_W-1:0]  rs1_id,
   input  logic [REG_ADDR_W-1:0]  rs2_id,
   input  logic                   flush,
   input  logic                   mc_done,
   input  logic [REG_ADDR_W-1:0]  mc_rd,
   output logic                   stall,
   output logic                   mc_busy,
   output logic [NREG-1:0]        pending_mask,
   output logic [STALL_CNT_W-1:0] stall_count
);

   localparam logic [PCNT_W-1:0] LOAD_INIT = PCNT_W'(LOAD_BUBBLES);

   logic [NREG-1:0]        not_ready_s;
   logic [NREG-1:0]        mc_pend_s;
   logic                   raw1_s;
   logic                   raw2_s;
   logic                   struct_s;
   logic                   waw_s;
   logic                   stall_s;
   logic                   accept_s;
   wr_kind_t               wr_kind_s;
   logic                   mc_busy_r;
   logic [STALL_CNT_W-1:0] stall_count_r;

   // Hazard detection and accept decision for the instruction sitting in ID.
   always_comb begin
      raw1_s   = use_rs1 && (rs1_id != REG_ZERO) && not_ready_s[rs1_id];
      raw2_s   = use_rs2 && (rs2_id != REG_ZERO) && not_ready_s[rs2_id];
      struct_s = issue_is_mc && mc_busy_r;
      waw_s    = issue_regwrite && (issue_rd != REG_ZERO) && mc_pend_s[issue_rd];
      if (issue_valid && !flush) begin
         stall_s = raw1_s || raw2_s || struct_s || waw_s;
      end else begin
         stall_s = 1'b0;
      end
      accept_s = issue_valid && !flush && !stall_s;
      if (accept_s) begin
         wr_kind_s = classify_write(issue_regwrite, issue_rd, issue_is_load, issue_is_mc);
      end else begin
         wr_kind_s = WR_NONE;
      end
   end

   for (genvar r = 0; r < NREG; r++) begin : g_entry
      if (r == 0) begin : g_zero
         assign not_ready_s[r] = 1'b0;
         assign mc_pend_s[r]   = 1'b0;
      end else begin : g_track
         logic [PCNT_W-1:0] pcnt_r;
         logic              mc_r;
         logic              write_s;
         logic              done_s;

         assign write_s = (wr_kind_s != WR_NONE) && (issue_rd == REG_ADDR_W'(r));
         assign done_s  = mc_done && (mc_rd == REG_ADDR_W'(r));

         // An accepted write re-arms the entry; otherwise the load countdown
         // keeps advancing, even while ID is stalled.
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               pcnt_r <= '0;
               mc_r   <= 1'b0;
            end else if (write_s) begin
               case (wr_kind_s)
                  WR_LOAD: begin
                     pcnt_r <= LOAD_INIT;
                     mc_r   <= 1'b0;
                  end
                  WR_MC: begin
                     pcnt_r <= '0;
                     mc_r   <= 1'b1;
                  end
                  default: begin
                     pcnt_r <= '0;
                     mc_r   <= 1'b0;
                  end
               endcase
            end else begin
               if (pcnt_r != '0) begin
                  pcnt_r <= pcnt_r - PCNT_W'(1);
               end
               if (done_s) begin
                  mc_r <= 1'b0;
               end
            end
         end

         assign not_ready_s[r] = (pcnt_r != '0) || mc_r;
         assign mc_pend_s[r]   = mc_r;
      end
   end

   // Single multicycle unit occupancy; a new issue overrides a same-cycle completion.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mc_busy_r <= 1'b0;
      end else if (wr_kind_s == WR_MC) begin
         mc_busy_r <= 1'b1;
      end else if (mc_done) begin
         mc_busy_r <= 1'b0;
      end
   end

   // Saturating count of stalled cycles.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_count_r <= '0;
      end else if (stall_s && (stall_count_r != '1)) begin
         stall_count_r <= stall_count_r + STALL_CNT_W'(1);
      end
   end

   assign stall        = stall_s;
   assign mc_busy      = mc_busy_r;
   assign pending_mask = not_ready_s;
   assign stall_count  = stall_count_r;

   hazard_scoreboard_checker u_checker (
      .clk      (clk),
      .rst      (rst),
      .mc_done  (mc_done),
      .mc_issue (wr_kind_s == WR_MC),
      .mc_busy  (mc_busy_r),
      .stall    (stall_s),
      .accept   (accept_s)
   );

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: directed scenarios with literal expectations,
// then randomized traffic compared each cycle against a cycle-stamp model.
module tb_hazard_scoreboard;

   localparam int LB = 1;

   logic        clk = 1'b0;
   logic        rst;
   logic        issue_valid = 1'b0;
   logic        issue_regwrite = 1'b0;
   logic [4:0]  issue_rd = 5'd0;
   logic        issue_is_load = 1'b0;
   logic        issue_is_mc = 1'b0;
   logic        use_rs1 = 1'b0;
   logic        use_rs2 = 1'b0;
   logic [4:0]  rs1_id = 5'd0;
   logic [4:0]  rs2_id = 5'd0;
   logic        flush = 1'b0;
   logic        mc_done = 1'b0;
   logic [4:0]  mc_rd = 5'd0;
   logic        stall;
   logic        mc_busy;
   logic [31:0] pending_mask;
   logic [31:0] stall_count;

   int errors = 0;
   int checks = 0;

   hazard_scoreboard #(.NREG(32), .LOAD_BUBBLES(LB), .STALL_CNT_W(32)) dut (
      .clk            (clk),
      .rst            (rst),
      .issue_valid    (issue_valid),
      .issue_regwrite (issue_regwrite),
      .issue_rd       (issue_rd),
      .issue_is_load  (issue_is_load),
      .issue_is_mc    (issue_is_mc),
      .use_rs1        (use_rs1),
      .use_rs2        (use_rs2),
      .rs1_id         (rs1_id),
      .rs2_id         (rs2_id),
      .flush          (flush),
      .mc_done        (mc_done),
      .mc_rd          (mc_rd),
      .stall          (stall),
      .mc_busy        (mc_busy),
      .pending_mask   (pending_mask),
      .stall_count    (stall_count)
   );

   always #5 clk = ~clk;

   // Model: each register carries the cycle number from which a load result
   // becomes forwardable, plus a "waiting on the multicycle unit" flag.
   longint unsigned cyc = 0;
   longint unsigned avail [32];
   bit              mcp   [32];
   bit              m_busy = 1'b0;
   longint unsigned m_count = 0;
   int              m_mc_rd = 0;

   function automatic bit m_nr(int r);
      return (r != 0) && ((cyc < avail[r]) || mcp[r]);
   endfunction

   function automatic bit m_stall();
      bit s;
      if (!issue_valid || flush) return 1'b0;
      s = (use_rs1 && m_nr(int'(rs1_id))) || (use_rs2 && m_nr(int'(rs2_id)));
      s = s || (issue_is_mc && m_busy);
      s = s || (issue_regwrite && issue_rd != 5'd0 && mcp[issue_rd]);
      return s;
   endfunction

   function automatic logic [31:0] m_mask();
      logic [31:0] m;
      for (int r = 0; r < 32; r++) m[r] = m_nr(r);
      return m;
   endfunction

   always @(posedge clk or posedge rst) begin
      bit s;
      bit acc;
      if (rst) begin
         for (int r = 0; r < 32; r++) begin
            avail[r] = 0;
            mcp[r] = 1'b0;
         end
         m_busy = 1'b0;
         m_count = 0;
         cyc = 0;
      end else begin
         s = m_stall();
         acc = issue_valid && !flush && !s;
         if (s && m_count != 64'hFFFF_FFFF) m_count++;
         if (mc_done) begin
            m_busy = 1'b0;
            if (mc_rd != 5'd0) mcp[mc_rd] = 1'b0;
         end
         if (acc && issue_regwrite && issue_rd != 5'd0) begin
            if (issue_is_load) begin
               avail[issue_rd] = cyc + 1 + LB;
               mcp[issue_rd] = 1'b0;
            end else if (issue_is_mc) begin
               avail[issue_rd] = 0;
               mcp[issue_rd] = 1'b1;
               m_busy = 1'b1;
               m_mc_rd = int'(issue_rd);
            end else begin
               avail[issue_rd] = 0;
               mcp[issue_rd] = 1'b0;
            end
         end
         cyc++;
      end
   end

   task automatic check(string name, longint unsigned act, longint unsigned exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Per-cycle comparison of all outputs against the model.
   always @(negedge clk) begin
      if (!rst) begin
         check("model_stall", stall, m_stall());
         check("model_mc_busy", mc_busy, m_busy);
         check("model_pending", pending_mask, m_mask());
         check("model_stall_count", stall_count, m_count);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic instr(bit v, bit rw, int rd, bit ld, bit mc, bit u1, int r1,
                        bit u2, int r2, bit fl);
      issue_valid = v;
      issue_regwrite = rw;
      issue_rd = 5'(rd);
      issue_is_load = ld;
      issue_is_mc = mc;
      use_rs1 = u1;
      rs1_id = 5'(r1);
      use_rs2 = u2;
      rs2_id = 5'(r2);
      flush = fl;
   endtask

   task automatic idle();
      instr(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   initial begin
      longint unsigned cnt_before;
      int k;
      rst = 1'b1;
      #2;
      check("reset_stall", stall, 0);
      check("reset_busy", mc_busy, 0);
      check("reset_mask", pending_mask, 0);
      check("reset_count", stall_count, 0);
      #10 rst = 1'b0;
      tick();

      // load-use
      instr(1, 1, 5, 1, 0, 0, 0, 0, 0, 0);
      tick();
      instr(1, 1, 9, 0, 0, 1, 5, 0, 0, 0);
      #2 check("loaduse_stall", stall, 1);
      check("loaduse_mask5", pending_mask[5], 1);
      tick();
      #2 check("loaduse_release", stall, 0);
      tick();
      check("loaduse_count", stall_count, 1);

      // ALU producer
      instr(1, 1, 6, 0, 0, 0, 0, 0, 0, 0);
      tick();
      instr(1, 1, 9, 0, 0, 0, 0, 1, 6, 0);
      #2 check("alu_stall", stall, 0);
      check("alu_mask6", pending_mask[6], 0);
      tick();

      // multicycle dependent
      instr(1, 1, 7, 0, 1, 0, 0, 0, 0, 0);
      tick();
      #2 check("div_busy", mc_busy, 1);
      instr(1, 1, 10, 0, 0, 1, 7, 0, 0, 0);
      for (int i = 0; i < 10; i++) begin
         #2 check("div_dep_hold", stall, 1);
         tick();
      end
      mc_done = 1'b1;
      mc_rd = 5'd7;
      #2 check("div_done_cycle", stall, 1);
      tick();
      mc_done = 1'b0;
      #2 check("div_dep_go", stall, 0);
      check("div_busy_clear", mc_busy, 0);
      tick();

      // structural and WAW
      instr(1, 1, 7, 0, 1, 0, 0, 0, 0, 0);
      tick();
      instr(1, 1, 11, 0, 1, 0, 0, 0, 0, 0);
      #2 check("struct_stall", stall, 1);
      tick();
      instr(1, 1, 7, 0, 0, 0, 0, 0, 0, 0);
      #2 check("waw_stall", stall, 1);
      tick();
      instr(1, 1, 8, 0, 0, 0, 0, 0, 0, 0);
      #2 check("other_rd_go", stall, 0);
      tick();
      idle();
      mc_done = 1'b1;
      mc_rd = 5'd7;
      tick();
      mc_done = 1'b0;
      instr(1, 1, 11, 0, 1, 0, 0, 0, 0, 0);
      #2 check("struct_release", stall, 0);
      tick();
      idle();
      mc_done = 1'b1;
      mc_rd = 5'd11;
      tick();
      mc_done = 1'b0;

      // x0 and flush
      instr(1, 1, 0, 1, 0, 0, 0, 0, 0, 0);
      tick();
      instr(1, 1, 13, 0, 0, 1, 0, 1, 0, 0);
      #2 check("x0_stall", stall, 0);
      check("x0_mask", pending_mask[0], 0);
      tick();
      instr(1, 1, 5, 1, 0, 0, 0, 0, 0, 0);
      tick();
      cnt_before = stall_count;
      instr(1, 1, 12, 1, 0, 1, 5, 0, 0, 1);
      #2 check("flush_stall", stall, 0);
      tick();
      check("flush_no_record", pending_mask[12], 0);
      check("flush_no_count", stall_count, cnt_before);
      idle();
      tick();

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         issue_valid = ($urandom_range(0, 9) < 8);
         k = $urandom_range(0, 5);
         issue_is_load = (k == 1);
         issue_is_mc = (k == 2);
         issue_regwrite = issue_is_mc ? 1'b1 : ($urandom_range(0, 4) != 0);
         issue_rd = issue_is_mc ? 5'($urandom_range(1, 7)) : 5'($urandom_range(0, 7));
         use_rs1 = $urandom_range(0, 1);
         use_rs2 = $urandom_range(0, 1);
         rs1_id = 5'($urandom_range(0, 7));
         rs2_id = 5'($urandom_range(0, 7));
         flush = ($urandom_range(0, 9) == 0);
         if (m_busy && $urandom_range(0, 5) == 0) begin
            mc_done = 1'b1;
            mc_rd = 5'(m_mc_rd);
         end else begin
            mc_done = 1'b0;
            mc_rd = 5'($urandom_range(0, 31));
         end
         tick();
      end
      idle();
      mc_done = 1'b0;
      if (m_busy) begin
         mc_done = 1'b1;
         mc_rd = 5'(m_mc_rd);
      end
      tick();
      mc_done = 1'b0;

      // reset mid-operation
      instr(1, 1, 7, 0, 1, 0, 0, 0, 0, 0);
      tick();
      instr(1, 1, 5, 1, 0, 0, 0, 0, 0, 0);
      tick();
      idle();
      check("pre_reset_busy", mc_busy, 1);
      check("pre_reset_mask", pending_mask & 32'h0000_00A0, 32'h0000_00A0);
      #1 rst = 1'b1;
      #1;
      check("async_reset_mask", pending_mask, 0);
      check("async_reset_busy", mc_busy, 0);
      check("async_reset_count", stall_count, 0);
      #2 rst = 1'b0;
      tick();
      tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
